alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Command-level controller in front of the 16-bit ALU. Takes one operation at a time over a
//  valid/ready command port, drives the ALU operand selects, operands and opcode through the
//  load/execute sequence, captures the 32-bit result and returns it on a valid/ready response port.
//  Screens illegal requests (no-op/error/reset codes, divide by zero, negative subtract) without
//  running the ALU, and supports chaining: operand B is the previous result.
// PARAMETERS
//  DATA_W   16  operand width (A, B)
//  RES_W    32  result width
//  EXEC_LAT 1   cycles from operand registration to result capture (>=1)
// PORTS
//  clk           in   1       system clock, all state on posedge
//  reset         in   1       asynchronous, active-high; clears all state
//  cmd_valid     in   1       command present
//  cmd_ready     out  1       sequencer can accept (IDLE only)
//  cmd_op        in   4       ALU opcode 0..15 (ALU encoding: 0 add .. 12 shift-right, 13 no-op, 14 error, 15 reset)
//  cmd_a         in   DATA_W  operand A
//  cmd_b         in   DATA_W  operand B (ignored when cmd_chain=1)
//  cmd_chain     in   1       1: B = low DATA_W bits of previous good result
//  alu_a         out  DATA_W  to ALU A input
//  alu_b         out  DATA_W  to ALU B input
//  alu_mux_a_sel out  2       2'b10 load A, 2'b01 hold
//  alu_mux_b_sel out  4       one-hot: 4'b0100 load B, 4'b0010 accumulator, 4'b0001 hold
//  alu_op        out  4       ALU opcode (registered)
//  alu_result    in   RES_W   ALU accumulator output (combinational from ALU operand regs)
//  rsp_valid     out  1       response held until accepted
//  rsp_ready     in   1       consumer accepts response
//  rsp_data      out  RES_W   captured result, 0 on error
//  rsp_err       out  1       request rejected
//  busy          out  1       state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, alu_a=alu_b=0,
//   alu_mux_a_sel=2'b01, alu_mux_b_sel=4'b0001, alu_op=4'd13, acc_valid=0, last_result=0.
//  FSM IDLE -> LOAD -> EXEC -> RESP -> IDLE; error path IDLE -> RESP.
//  IDLE: cmd_ready=1; accept on cmd_valid&cmd_ready posedge; latch op/a/b/chain.
//   Effective B = cmd_chain ? last_result[DATA_W-1:0] : cmd_b.
//   Reject (rsp_err=1, rsp_data=0, next RESP) if: op>=13; chain with acc_valid=0;
//   op==3 and effective B==0; op==1 and effective B > cmd_a. Rejects leave ALU untouched.
//  LOAD (1 cycle): alu_a=cmd_a, alu_mux_a_sel=2'b10; alu_mux_b_sel=4'b0100 with alu_b=cmd_b,
//   or 4'b0010 when chained. alu_op keeps previous value so accumulator path carries last result.
//  EXEC (EXEC_LAT cycles): selects hold (2'b01/4'b0001), alu_op=latched op from first EXEC cycle;
//   on last EXEC cycle capture alu_result into rsp_data and last_result, set acc_valid=1.
//  RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_valid&rsp_ready; then IDLE same edge.
//   Back-to-back: new command accepted earliest the cycle after the response handshake.
//  Latency good op: accept edge to rsp_valid = 2+EXEC_LAT cycles. Rejected op: 1 cycle.
//  Outside LOAD, selects are always hold; alu_op never changes outside EXEC entry.
//  acc_valid cleared only by reset; rejected ops do not modify last_result/acc_valid.
//  Width: rsp_data = alu_result exactly (RES_W); chaining truncates to low DATA_W bits.
//  Reset mid-operation: abort immediately, any pending response discarded, reset values.
//  cmd_valid while busy: ignored (cmd_ready=0), command must be held by the producer.
// TESTING
//  1 add: A=5,B=6,op=0 -> rsp_valid after 3 cycles, rsp_data=11, rsp_err=0.
//  2 chain: then op=2,A=4,chain=1 -> B=11, rsp_data=44; alu_mux_b_sel=4'b0010 during LOAD.
//  3 rejects: op=3,B=0 -> err, data 0, 1-cycle latency; op=1,A=3,B=7 -> err; op=14 -> err;
//    chain right after reset -> err; alu_mux selects stay hold throughout.
//  4 backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0;
//    release -> IDLE next cycle, next command accepted.
//  5 reset during EXEC of op=2 A=300,B=300 -> all outputs at reset values, no response, acc_valid=0.
//  6 wide result: op=2 A=B=16'hFFFF -> rsp_data=32'hFFFE0001; chained next uses B=16'h0001.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command-level load/execute/respond sequencer for the 16-bit ALU
module alu_cmd_sequencer #(
    parameter int DATA_W   = 16,
    parameter int RES_W    = 32,
    parameter int EXEC_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_chain,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_mux_a_sel,
    output logic [3:0]        alu_mux_b_sel,
    output logic [3:0]        alu_op,
    input  logic [RES_W-1:0]  alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    // ALU opcodes that the screening logic cares about
    localparam logic [3:0] OP_SUB         = 4'd1;
    localparam logic [3:0] OP_DIV         = 4'd3;
    localparam logic [3:0] OP_NOP         = 4'd13;
    localparam logic [3:0] OP_FIRST_ILLEG = 4'd13;

    // ALU operand mux encodings
    localparam logic [1:0] A_SEL_LOAD = 2'b10;
    localparam logic [1:0] A_SEL_HOLD = 2'b01;
    localparam logic [3:0] B_SEL_LOAD = 4'b0100;
    localparam logic [3:0] B_SEL_ACC  = 4'b0010;
    localparam logic [3:0] B_SEL_HOLD = 4'b0001;

    localparam int CNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [3:0]         op_q;
    logic [CNT_W-1:0]   exec_cnt;
    logic [DATA_W-1:0]  last_result;
    logic               acc_valid;

    logic [DATA_W-1:0]  eff_b;
    logic               reject;
    logic               accept;
    logic               exec_last;

    // Chained commands take B from the low bits of the last good result;
    // the ALU's accumulator path carries the same value during LOAD.
    assign eff_b = cmd_chain ? last_result : cmd_b;

    // Screen requests the ALU must never see: reserved codes, chaining with
    // no prior result, divide by zero and subtracts that would go negative.
    assign reject = (cmd_op >= OP_FIRST_ILLEG)
                  | (cmd_chain & ~acc_valid)
                  | ((cmd_op == OP_DIV) & (eff_b == '0))
                  | ((cmd_op == OP_SUB) & (eff_b > cmd_a));

    assign accept    = cmd_valid & cmd_ready;
    assign exec_last = (state_q == S_EXEC) && (exec_cnt == CNT_W'(EXEC_LAT - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; rejected commands skip straight to RESP
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_d = reject ? S_RESP : S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (exec_last) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ALU drive, exec timing, result capture and chaining history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_mux_a_sel <= A_SEL_HOLD;
            alu_mux_b_sel <= B_SEL_HOLD;
            alu_op        <= OP_NOP;
            op_q          <= OP_NOP;
            exec_cnt      <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            last_result   <= '0;
            acc_valid     <= 1'b0;
        end else begin
            // Selects are load only for the single LOAD cycle
            alu_mux_a_sel <= A_SEL_HOLD;
            alu_mux_b_sel <= B_SEL_HOLD;

            if (accept) begin
                if (reject) begin
                    rsp_err  <= 1'b1;
                    rsp_data <= '0;
                end else begin
                    alu_a         <= cmd_a;
                    alu_mux_a_sel <= A_SEL_LOAD;
                    op_q          <= cmd_op;
                    exec_cnt      <= '0;
                    if (cmd_chain) begin
                        // alu_op is left alone so the accumulator still shows the last result
                        alu_mux_b_sel <= B_SEL_ACC;
                    end else begin
                        alu_b         <= cmd_b;
                        alu_mux_b_sel <= B_SEL_LOAD;
                    end
                end
            end

            // Opcode switches as EXEC is entered, once operands are in the ALU
            if (state_q == S_LOAD) begin
                alu_op <= op_q;
            end

            if (state_q == S_EXEC) begin
                exec_cnt <= exec_cnt + 1'b1;
                if (exec_last) begin
                    rsp_data    <= alu_result;
                    rsp_err     <= 1'b0;
                    last_result <= alu_result[DATA_W-1:0];
                    acc_valid   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer with an ALU stand-in
module tb_alu_cmd_sequencer;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = 4'd0;
    logic [15:0] cmd_a = 16'd0;
    logic [15:0] cmd_b = 16'd0;
    logic        cmd_chain = 1'b0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_mux_a_sel;
    logic [3:0]  alu_mux_b_sel;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    alu_cmd_sequencer #(.DATA_W(16), .RES_W(32), .EXEC_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mux_a_sel(alu_mux_a_sel),
        .alu_mux_b_sel(alu_mux_b_sel), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'd0:    return {16'd0, a} + {16'd0, b};
            4'd1:    return {16'd0, a - b};
            4'd2:    return {16'd0, a} * {16'd0, b};
            4'd3:    return (b == 16'd0) ? 32'd0 : {16'd0, a / b};
            4'd4:    return {16'd0, a & b};
            4'd5:    return {16'd0, a | b};
            4'd6:    return {16'd0, a ^ b};
            4'd11:   return {16'd0, a} << b[3:0];
            4'd12:   return {16'd0, a >> b[3:0]};
            default: return 32'd0;
        endcase
    endfunction

    // ALU stand-in: operand registers loaded through the muxes, combinational result
    logic [15:0] ra, rb;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ra <= 16'd0;
            rb <= 16'd0;
        end else begin
            if (alu_mux_a_sel == 2'b10) ra <= alu_a;
            if (alu_mux_b_sel == 4'b0100) rb <= alu_b;
            else if (alu_mux_b_sel == 4'b0010) rb <= alu_result[15:0];
        end
    end
    assign alu_result = alu_fn(alu_op, ra, rb);

    // Behavioural model: expected responses and ALU-control expectations per cycle
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;
    exp_t        exp_q[$];
    logic [15:0] m_last;
    logic        m_acc;
    logic [3:0]  op_old, op_new;
    int          op_switch;
    int          load_cyc;
    logic        load_chain;
    logic        prev_v = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last     = 16'd0;
        m_acc      = 1'b0;
        op_old     = 4'd13;
        op_new     = 4'd13;
        op_switch  = 0;
        load_cyc   = -1;
        load_chain = 1'b0;
    endtask

    task automatic model_accept(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic chain, input int acc);
        logic [15:0] eb;
        logic [3:0]  cur;
        exp_t        e;
        eb = chain ? m_last : b;
        e.err  = (op >= 4'd13) || (chain && !m_acc) || (op == 4'd3 && eb == 16'd0) ||
                 (op == 4'd1 && eb > a);
        e.data = e.err ? 32'd0 : alu_fn(op, a, eb);
        e.acc  = acc;
        e.lat  = e.err ? 1 : 2 + LAT;
        exp_q.push_back(e);
        if (!e.err) begin
            cur        = (acc >= op_switch) ? op_new : op_old;
            op_old     = cur;
            op_new     = op;
            op_switch  = acc + 1;
            load_cyc   = acc;
            load_chain = chain;
            m_last     = e.data[15:0];
            m_acc      = 1'b1;
        end
    endtask

    // Compare process: every cycle out of reset
    always @(negedge clk) begin
        if (!reset) begin
            chk("cmd_ready_vs_busy", {31'd0, cmd_ready}, {31'd0, !busy});
            chk("mux_a_sel", {30'd0, alu_mux_a_sel}, (cyc == load_cyc) ? 32'd2 : 32'd1);
            chk("mux_b_sel", {28'd0, alu_mux_b_sel},
                (cyc == load_cyc) ? (load_chain ? 32'd2 : 32'd4) : 32'd1);
            chk("alu_op", {28'd0, alu_op}, {28'd0, (cyc >= op_switch) ? op_new : op_old});
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response (t=%0t)", $time);
                end else begin
                    if (!prev_v) chk("rsp_latency", cyc - exp_q[0].acc + 1, exp_q[0].lat);
                    chk("rsp_data", rsp_data, exp_q[0].data);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_q[0].err});
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
            prev_v = rsp_valid;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
        chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_alu_a"}, {16'd0, alu_a}, 32'd0);
        chk({tag, "_alu_b"}, {16'd0, alu_b}, 32'd0);
        chk({tag, "_mux_a"}, {30'd0, alu_mux_a_sel}, 32'd1);
        chk({tag, "_mux_b"}, {28'd0, alu_mux_b_sel}, 32'd1);
        chk({tag, "_alu_op"}, {28'd0, alu_op}, 32'd13);
    endtask

    // Called just after a posedge; returns just after the posedge that resets
    task automatic do_reset(input string tag);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_state(tag);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Present a command until accepted; returns 1 time unit after the accept edge
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic chain, output int acc);
        bit ok = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain; cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (ok) begin
            acc = cyc;
            model_accept(op, a, b, chain, acc);
        end else begin
            n_checks++;
            n_err++;
            $display("FAIL issue_timeout: got cmd_ready=0 for 50 cycles expected 1");
        end
        cmd_valid = 1'b0;
    endtask

    // Wait for a response handshake; returns 1 time unit after the handshake edge
    task automatic wait_rsp(output logic [31:0] d, output logic e, output int cap);
        bit got = 0;
        d = 32'd0; e = 1'b0; cap = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                d = rsp_data; e = rsp_err; cap = cyc; got = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!got) begin
            n_checks++;
            n_err++;
            $display("FAIL rsp_timeout: got no response in 50 cycles expected one");
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          acc, cap;
        bit          seen;

        model_reset();
        @(posedge clk);
        #1;
        do_reset("rst");

        // 1: plain add
        issue(4'd0, 16'd5, 16'd6, 1'b0, acc);
        wait_rsp(d, e, cap);
        chk("add_data", d, 32'd11);
        chk("add_err", {31'd0, e}, 32'd0);
        chk("add_latency", cap - acc + 1, 32'd3);

        // 2: chained multiply, B comes from the accumulator
        issue(4'd2, 16'd4, 16'd999, 1'b1, acc);
        @(negedge clk);
        chk("chain_load_b_sel", {28'd0, alu_mux_b_sel}, 32'h2);
        chk("chain_load_a_sel", {30'd0, alu_mux_a_sel}, 32'h2);
        wait_rsp(d, e, cap);
        chk("chain_data", d, 32'd44);

        // 3: rejects
        issue(4'd3, 16'd9, 16'd0, 1'b0, acc);
        wait_rsp(d, e, cap);
        chk("div0_err", {31'd0, e}, 32'd1);
        chk("div0_data", d, 32'd0);
        chk("div0_latency", cap - acc + 1, 32'd1);
        issue(4'd1, 16'd3, 16'd7, 1'b0, acc);
        wait_rsp(d, e, cap);
        chk("negsub_err", {31'd0, e}, 32'd1);
        issue(4'd14, 16'd1, 16'd1, 1'b0, acc);
        wait_rsp(d, e, cap);
        chk("op14_err", {31'd0, e}, 32'd1);
        do_reset("rst2");
        issue(4'd0, 16'd1, 16'd0, 1'b1, acc);
        wait_rsp(d, e, cap);
        chk("chain_after_reset_err", {31'd0, e}, 32'd1);

        // 4: response backpressure
        rsp_ready = 1'b0;
        issue(4'd0, 16'd100, 16'd23, 1'b0, acc);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        chk("bp_rsp_seen", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_data", rsp_data, 32'd123);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);
        chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        issue(4'd0, 16'd1, 16'd2, 1'b0, acc);
        wait_rsp(d, e, cap);
        chk("bp_next_data", d, 32'd3);

        // 5: reset while the multiply is in EXEC
        issue(4'd2, 16'd300, 16'd300, 1'b0, acc);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_state("abort");
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        issue(4'd0, 16'd1, 16'd0, 1'b1, acc);
        wait_rsp(d, e, cap);
        chk("abort_acc_cleared", {31'd0, e}, 32'd1);

        // 6: full-width result and truncated chaining
        issue(4'd2, 16'hFFFF, 16'hFFFF, 1'b0, acc);
        wait_rsp(d, e, cap);
        chk("wide_data", d, 32'hFFFE0001);
        issue(4'd0, 16'd2, 16'd0, 1'b1, acc);
        wait_rsp(d, e, cap);
        chk("wide_chain_data", d, 32'd3);
        issue(4'd1, 16'd0, 16'd0, 1'b1, acc);
        wait_rsp(d, e, cap);
        chk("chain_negsub_err", {31'd0, e}, 32'd1);
        issue(4'd1, 16'd5, 16'd0, 1'b1, acc);
        wait_rsp(d, e, cap);
        chk("chain_sub_data", d, 32'd2);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
